// File: rtl/fp_mul_scheduler.sv
// rtl/fp_mul_scheduler.sv - round-robin scheduler sharing one fp multiplier among N_REQ requesters
// Optional FP_MUL_ZERO_BYPASS_EN: zero operands skip the multicycle wait and return signed zero.
module fp_mul_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic [31:0]        resp_data,
  output logic               busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic              grant_found;
  logic              hs;
  logic              bypass_hit;
  logic [31:0]       a_sel, b_sel;
  logic [31:0]       a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       mul_out;

  // Truncating single-precision multiply; implicit one always assumed, exponent wraps.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] prod;
    logic [7:0]  exp_r;
    logic [22:0] mant_r;
    prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    exp_r  = a[30:23] + b[30:23] - 8'd127 + {7'd0, prod[47]};
    mant_r = prod[47] ? prod[46:24] : prod[45:23];
    return {a[31] ^ b[31], exp_r, mant_r};
  endfunction

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant       = ID_W'(idx);
      end
    end
  end

  assign a_sel = req_a[32*int'(grant) +: 32];
  assign b_sel = req_b[32*int'(grant) +: 32];
  assign hs    = (state == S_IDLE) && grant_found && rst_n;

`ifdef FP_MUL_ZERO_BYPASS_EN
  assign bypass_hit = (a_sel[30:0] == 31'd0) || (b_sel[30:0] == 31'd0);
`else
  assign bypass_hit = 1'b0;
`endif

  // Multiplier sees only the registered operands, giving it LATENCY cycles to settle.
  assign mul_out = fp_mul(a_q, b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (grant_found) state_nx = bypass_hit ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == '0) state_nx = S_RESP;
      S_RESP: if (resp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[grant] = 1'b1;
    resp_valid = (state == S_RESP);
    busy       = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      cnt       <= '0;
      resp_data <= '0;
      resp_id   <= '0;
    end else begin
      if (hs) begin
        a_q    <= a_sel;
        b_q    <= b_sel;
        id_q   <= grant;
        rr_ptr <= ID_W'((int'(grant) + 1) % N_REQ);
        cnt    <= CNT_W'(LATENCY - 1);
        if (bypass_hit) begin
          resp_data <= {a_sel[31] ^ b_sel[31], 31'd0};
          resp_id   <= grant;
        end
      end
      if (state == S_WAIT) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          resp_data <= mul_out;
          resp_id   <= id_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// tb/tb_fp_mul_scheduler.sv - self-checking bench for fp_mul_scheduler with a behavioural reference model
module tb_fp_mul_scheduler;

  localparam int N = 4;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [1:0]   resp_id;
  logic [31:0]  resp_data;
  logic         busy;

  int checks = 0;
  int fails  = 0;
  int rr     = 0;

  fp_mul_scheduler #(.N_REQ(N), .ID_W(2), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bypass(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_MUL_ZERO_BYPASS_EN
    return (a[30:0] == 0) || (b[30:0] == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Value-level model: significands as integers, normalise by magnitude, truncate.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, p, frac;
    int e;
    if (is_bypass(a, b)) return {a[31] ^ b[31], 31'd0};
    ma = 64'h800000 + longint'(a[22:0]);
    mb = 64'h800000 + longint'(b[22:0]);
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= (64'd1 << 47)) begin
      frac = (p / (64'd1 << 24)) % (64'd1 << 23);
      e    = e + 1;
    end else begin
      frac = (p / (64'd1 << 23)) % (64'd1 << 23);
    end
    e = ((e % 256) + 256) % 256;
    return {a[31] ^ b[31], 8'(e), 23'(frac)};
  endfunction

  function automatic int pick(input logic [3:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  // Enter at posedge+1 in IDLE; leave at posedge+1 back in IDLE.
  task automatic op(input logic [3:0] v, input logic [127:0] a, input logic [127:0] b,
                    input int bp, output logic [31:0] got_data, output logic [1:0] got_id);
    int g, n;
    logic [31:0] exp;
    bit byp;
    g = pick(v);
    req_valid = v; req_a = a; req_b = b;
    #1;
    chk("req_ready_grant", {28'd0, req_ready}, 32'd1 << g);
    exp = ref_mul(a[32*g +: 32], b[32*g +: 32]);
    byp = is_bypass(a[32*g +: 32], b[32*g +: 32]);
    @(posedge clk); #1;
    req_valid = '0;
    rr = (g + 1) % N;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, byp ? 0 : L);
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_data", resp_data, exp);
    chk("resp_id", {30'd0, resp_id}, g);
    got_data = resp_data;
    got_id   = resp_id;
    for (int c = 0; c < bp; c++) begin
      req_valid = 4'hF;
      @(posedge clk); #1;
      chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_data_stable", resp_data, exp);
      chk("bp_id_stable", {30'd0, resp_id}, g);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_drop", {31'd0, resp_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0]  d;
    logic [1:0]   id;
    logic [127:0] ra, rb;
    logic [3:0]   rv;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single op 1.5 * 2.0 on requester 0
    op(4'b0001, {96'd0, 32'h3FC00000}, {96'd0, 32'h40000000}, 0, d, id);
    chk("t2_data", d, 32'h40400000);
    chk("t2_id", {30'd0, id}, 32'd0);

    // reset in the middle of WAIT drops the op
    req_valid = 4'b0001; req_a = {96'd0, 32'h40000000}; req_b = {96'd0, 32'h40400000};
    @(posedge clk); #1;
    chk("t1_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_req_ready", {28'd0, req_ready}, 32'd0);
    chk("t1_resp_data", resp_data, 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("t1_no_stale", {31'd0, resp_valid}, 32'd0);
    end

    // round robin with all requesters active
    for (int i = 0; i < 5; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      op(4'b1111, ra, rb, 0, d, id);
      chk("t3_rr_order", {30'd0, id}, i % N);
    end

    // backpressure 2.0 * 3.0, resp_ready low for 5 cycles
    op(4'b0010, {64'd0, 32'h40000000, 32'd0}, {64'd0, 32'h40400000, 32'd0}, 5, d, id);
    chk("t4_data", d, 32'h40C00000);
    chk("t4_id", {30'd0, id}, 32'd1);

    // wrap: push pointer to 3 then request 0 and 2
    op(4'b0100, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, d, id);
    op(4'b0101, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, d, id);
    chk("t5_wrap_grant", {30'd0, id}, 32'd0);
    op(4'b1111, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, d, id);
    chk("t5_next_ptr", {30'd0, id}, 32'd1);

    // zero operand
    op(4'b0001, {96'd0, 32'h80000000}, {96'd0, 32'h40400000}, 0, d, id);
`ifdef FP_MUL_ZERO_BYPASS_EN
    chk("t6_zero", d, 32'h80000000);
`else
    chk("t6_zero", d, 32'h80C00000);
`endif

    // random traffic
    for (int i = 0; i < 24; i++) begin
      rv = 4'($urandom_range(1, 15));
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 5) == 0) ra[31:0] = {ra[31], 31'd0};
      op(rv, ra, rb, $urandom_range(0, 3), d, id);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
